key_schedule_192_seq: RTL
=========================

// Module: key_schedule_192_seq
// PURPOSE
//  Sequential AES-192 key schedule. Accepts a 192-bit cipher key and streams the 13
//  128-bit round keys (w[4k..4k+3], k=0..12) to the round datapath over a valid/ready
//  interface. Iterates get_new_keys_192 (6 words per step) and regroups 6-word groups
//  into 4-word round keys through a 12-word sliding window.
// PARAMETERS
//  NUM_RK     13  number of round keys emitted (fixed for AES-192; not for override)
//  GRP_WORDS  6   words produced per expansion step
// PORTS
//  clk        in   1    clock, all state updates on posedge
//  rst_n      in   1    synchronous active-low reset
//  key_in     in   192  cipher key; key_in[191:160] = w0 ... key_in[31:0] = w5
//  key_valid  in   1    key_in valid
//  key_ready  out  1    high only in IDLE; key accepted when key_valid && key_ready
//  rk_data    out  128  round key k; rk_data[127:96] = w[4k] ... [31:0] = w[4k+3]
//  rk_idx     out  4    round-key index k, 0..12
//  rk_valid   out  1    rk_data/rk_idx valid
//  rk_ready   in   1    consumer accepts when rk_valid && rk_ready
//  busy       out  1    high in EMIT
//  done       out  1    one-cycle pulse the cycle after round key 12 is accepted
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, rk_valid=0, rk_idx=0, rk_data=0, done=0,
//    busy=0, window cleared, offset=0, iter=0. Reset mid-stream aborts immediately.
//  - Window win[0:11] = groups {g, g+1}; offset in {0,2,4} (always <=4 at a handshake,
//    so win[offset..offset+3] never overruns); rk_data = win[offset +: 4].
//  - FSM IDLE: key_ready=1. On key handshake: win[0:5]=key words, win[6:11]=
//    get_new_keys_192(key, round=1), offset=0, rk_idx=0, iter=2 -> EMIT.
//    rk_valid high the cycle after acceptance (latency 1).
//  - FSM EMIT: rk_valid=1, key_ready=0 (key_valid ignored). On rk handshake with
//    rk_idx<12: rk_idx++, n=offset+4; if n>=6: win[0:5]=win[6:11],
//    win[6:11]=get_new_keys_192(win[6:11], round=iter), iter++, offset=n-6; else offset=n.
//    Shift occurs after k=1,2,4,5,7,8,10,11 (offset sequence 0,4,2,0,4,2,...).
//    Group computed on the shift after k=11 (iter=9) is never emitted.
//  - On rk handshake with rk_idx==12: -> IDLE, rk_valid=0, done=1 next cycle only.
//  - Backpressure: while rk_valid && !rk_ready, rk_data, rk_idx, window, offset stable.
//  - Full rate: with rk_ready held high, 13 keys in 13 consecutive cycles; a new key
//    is accepted no earlier than the cycle done is high (IDLE entered).
//  - round input to get_new_keys_192 is the 4-bit iter; rcon_vals[1]=32'h0100_0000.
// STRUCTURE
//  - function_package: existing rot_word, sub_word, rcon_vals; add word_t (logic [31:0])
//    and ks192_state_t enum {IDLE, EMIT}.
//  - One combinational instance of get_new_keys_192 (in = mux(IDLE: key words,
//    EMIT: win[6:11]); round = IDLE ? 1 : iter); all registers in this module.
// TESTING
//  1 FIPS-197 A.2 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, rk_ready=1 ->
//    rk0=8e73b0f7da0e6452c810f32b809079e5, rk1=62f8ead2522c6b7bfe0c91f72402f5a5,
//    rk12=e98ba06f448c773c8ecc720401002202; 13 consecutive valid cycles, done 1 pulse.
//  2 Same key, rk_ready random 50% -> identical 13-key sequence, outputs stable while
//    stalled, rk_idx strictly 0..12 without gaps; compare all keys to C reference model.
//  3 key_valid pulsed with new key during EMIT -> ignored (key_ready=0), stream
//    unchanged; key accepted only once IDLE.
//  4 rst_n=0 for one cycle after rk_idx=5 accepted -> next cycle rk_valid=0,
//    key_ready=1, done=0; reload FIPS key -> full correct sequence from rk0.
//  5 Back-to-back: second key (all-zero) presented with key_valid held -> accepted in
//    done cycle; rk0=0, rk1=00000000000000006263636362636363.

Source files
------------

// File: rtl/key_schedule_192_seq_pkg.sv
// Shared types, constants and helper functions for the sequential AES-192 key schedule.
//   word_t            : one 32-bit key-schedule word
//   grp_t             : six packed words, word 0 in the top bits
//   ks192_state_t     : controller state {IDLE, EMIT}
//   rot_word/sub_word : AES word rotation and S-box substitution
//   get_new_keys_192  : next six expanded words from the previous six
package key_schedule_192_seq_pkg;

    localparam int NUM_RK    = 13;
    localparam int GRP_WORDS = 6;
    localparam int WIN_WORDS = 2 * GRP_WORDS;

    localparam logic [3:0] LAST_RK = 4'(NUM_RK - 1);

    typedef logic [31:0]              word_t;
    typedef logic [GRP_WORDS*32-1:0]  grp_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } ks192_state_t;

    // Indexed directly by the 4-bit round number; index 0 and 11..15 are unused.
    localparam word_t rcon_vals [16] = '{
        32'h0000_0000, 32'h0100_0000, 32'h0200_0000, 32'h0400_0000,
        32'h0800_0000, 32'h1000_0000, 32'h2000_0000, 32'h4000_0000,
        32'h8000_0000, 32'h1b00_0000, 32'h3600_0000, 32'h0000_0000,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000
    };

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as a^254 (multiplicative inverse, 0 -> 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Only the first word of a group sees the rotate/substitute/rcon term; the rest chain.
    function automatic grp_t get_new_keys_192(input grp_t prev_grp, input logic [3:0] round);
        grp_t  nxt;
        word_t carry;
        word_t w;
        carry = sub_word(rot_word(prev_grp[31:0])) ^ rcon_vals[round];
        for (int i = 0; i < GRP_WORDS; i++) begin
            w = prev_grp[GRP_WORDS*32-1-32*i -: 32] ^ carry;
            nxt[GRP_WORDS*32-1-32*i -: 32] = w;
            carry = w;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/key_schedule_192_seq_if.sv
// Key-in / round-key-out bundle for key_schedule_192_seq.
//   Both channels use valid/ready: a transfer happens on a rising clk edge where valid
//   and ready are both high; the sender holds its payload stable while valid && !ready.
//   slave  : the key schedule (consumes key_in, produces rk_*, busy, done)
//   master : the environment (produces key_in, consumes round keys)
interface key_schedule_192_seq_if;
    logic [191:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;

    modport slave (
        input  key_in, key_valid, rk_ready,
        output key_ready, rk_data, rk_idx, rk_valid, busy, done
    );

    modport master (
        output key_in, key_valid, rk_ready,
        input  key_ready, rk_data, rk_idx, rk_valid, busy, done
    );
endinterface

// File: rtl/key_schedule_192_seq_expand.sv
// Combinational one-step AES-192 expansion: six words in, next six words out.
//   grp_in   : previous group, word 0 in [191:160]
//   round    : rcon index for this step
//   grp_out  : next group, same word ordering
module key_schedule_192_seq_expand
    import key_schedule_192_seq_pkg::*;
(
    input  grp_t       grp_in,
    input  logic [3:0] round,
    output grp_t       grp_out
);
    assign grp_out = get_new_keys_192(grp_in, round);
endmodule

// File: rtl/key_schedule_192_seq.sv
// Sequential AES-192 key schedule. Takes a 192-bit key and streams the 13 round keys,
// one per accepted handshake, regrouping 6-word expansion groups through a 12-word window.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : key input and round-key output channels (slave side)
//   state_dbg  : current controller state
module key_schedule_192_seq
    import key_schedule_192_seq_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    key_schedule_192_seq_if.slave         bus,
    output ks192_state_t                  state_dbg
);
    ks192_state_t state, state_nxt;

    word_t      win [WIN_WORDS];
    logic [2:0] offset;
    logic [3:0] iter;
    logic [3:0] rk_idx;
    logic       done_q;

    logic key_hs;
    logic rk_hs;
    logic last_hs;

    grp_t       exp_in;
    grp_t       exp_out;
    logic [3:0] exp_round;
    logic [127:0] rk_data_c;

    assign key_hs  = (state == IDLE) && bus.key_valid;
    assign rk_hs   = (state == EMIT) && bus.rk_ready;
    assign last_hs = rk_hs && (rk_idx == LAST_RK);

    // The single expander is shared: in IDLE it extends the incoming key, in EMIT it
    // extends the newer half of the window.
    always_comb begin
        exp_in = bus.key_in;
        if (state == EMIT) begin
            for (int i = 0; i < GRP_WORDS; i++) begin
                exp_in[GRP_WORDS*32-1-32*i -: 32] = win[GRP_WORDS + i];
            end
        end
        exp_round = (state == IDLE) ? 4'd1 : iter;
    end

    key_schedule_192_seq_expand u_expand (
        .grp_in  (exp_in),
        .round   (exp_round),
        .grp_out (exp_out)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (key_hs)  state_nxt = EMIT;
            EMIT:    if (last_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.key_ready = (state == IDLE);
        bus.rk_valid  = (state == EMIT);
        bus.busy      = (state == EMIT);
    end

    // offset is at most 4 here, so offset+3 stays inside the 12-word window.
    always_comb begin
        rk_data_c = '0;
        for (int j = 0; j < 4; j++) begin
            rk_data_c[127-32*j -: 32] = win[{1'b0, offset} + 4'(j)];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN_WORDS; i++) win[i] <= '0;
            offset <= '0;
            iter   <= '0;
            rk_idx <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last_hs;
            if (key_hs) begin
                for (int i = 0; i < GRP_WORDS; i++) begin
                    win[i]             <= bus.key_in[191-32*i -: 32];
                    win[GRP_WORDS + i] <= exp_out[191-32*i -: 32];
                end
                offset <= '0;
                rk_idx <= '0;
                iter   <= 4'd2;
            end else if (rk_hs && !last_hs) begin
                rk_idx <= rk_idx + 4'd1;
                // offset+4 >= 6 exactly when offset >= 2: slide the window by one group.
                if (offset >= 3'd2) begin
                    for (int i = 0; i < GRP_WORDS; i++) begin
                        win[i]             <= win[GRP_WORDS + i];
                        win[GRP_WORDS + i] <= exp_out[191-32*i -: 32];
                    end
                    iter   <= iter + 4'd1;
                    offset <= offset - 3'd2;
                end else begin
                    offset <= offset + 3'd4;
                end
            end
        end
    end

    assign bus.rk_data = rk_data_c;
    assign bus.rk_idx  = rk_idx;
    assign bus.done    = done_q;
    assign state_dbg   = state;

endmodule
